// File: rtl/cache_bus_arbiter_pkg.sv
// cache_bus_arbiter_pkg
// Shared bus types and FSM state encodings for the core-side cache bus.
// Used by the bus arbiter and by any block that drives or consumes the
// cache_bus request/response structs.
package cache_bus_arbiter_pkg;

  // Upstream/downstream request. data_ok/data_last carry the write-data
  // handshake on writes, and the "ready to accept read data" qualifier on reads.
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [7:0]  len;
    logic [31:0] w_data;
    logic        data_ok;
    logic        data_last;
  } cache_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] r_data;
    logic        data_ok;
    logic        data_last;
  } cache_bus_resp_t;

  localparam logic [2:0] ST_IDLE_ENC = 3'b001;
  localparam logic [2:0] ST_ADDR_ENC = 3'b010;
  localparam logic [2:0] ST_DATA_ENC = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_ADDR = ST_ADDR_ENC,
    ST_DATA = ST_DATA_ENC
  } arb_state_t;

endpackage

// File: rtl/cache_bus_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin picker. The search starts one past the previous
// winner and wraps, so the previous winner has the lowest priority.
// Ports:
//   req   in  N   request vector
//   last  in  LW  index of the previous winner
//   grant out N   one-hot winner, 0 when no request is pending
module rr_picker #(
  parameter int N  = 2,
  parameter int LW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
// Shares one downstream cache_bus port between N_MASTER requesters with
// round-robin arbitration. A grant is held from address acceptance through
// the final data beat, so transactions never interleave.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   m_req_i     upstream requests, one per master
//   m_resp_o    upstream responses; only the owner sees ready/data_ok/data_last
//   s_req_o     downstream request (owner's fields, valid only in address phase)
//   s_resp_i    downstream response
//   grant_o     one-hot current owner, 0 when idle
//   busy_o      high while a transaction is in progress
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int N_MASTER = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  cache_bus_req_t  [N_MASTER-1:0]  m_req_i,
  output cache_bus_resp_t [N_MASTER-1:0]  m_resp_o,
  output cache_bus_req_t                  s_req_o,
  input  cache_bus_resp_t                 s_resp_i,
  output logic [N_MASTER-1:0]             grant_o,
  output logic                            busy_o
);

  localparam int LW = (N_MASTER > 2) ? 2 : 1;

  arb_state_t            state_q, state_d;
  logic [N_MASTER-1:0]   grant_q, grant_d;
  logic [LW-1:0]         last_q, last_d;
  logic [LW-1:0]         owner, win_idx;
  logic [N_MASTER-1:0]   req_vec, pick;
  logic                  xfer_done;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < N_MASTER; i++) req_vec[i] = m_req_i[i].valid;
  end

  rr_picker #(.N(N_MASTER), .LW(LW)) u_picker (
    .req   (req_vec),
    .last  (last_q),
    .grant (pick)
  );

  // One-hot to index for the owner and for the fresh winner.
  always_comb begin
    owner   = '0;
    win_idx = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (grant_q[i]) owner   = LW'(i);
      if (pick[i])    win_idx = LW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LW'(N_MASTER - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d = ST_ADDR;
          grant_d = pick;
          last_d  = win_idx;
        end
      end
      ST_ADDR: begin
        if (s_resp_i.ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (xfer_done) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    s_req_o = '0;
    if (state_q != ST_IDLE) begin
      s_req_o       = m_req_i[owner];
      s_req_o.valid = (state_q == ST_ADDR);
      if (state_q != ST_DATA) s_req_o.data_ok = 1'b0;
    end
  end

  // Writes finish on the master's last beat; reads on the slave's last beat.
  assign xfer_done = s_resp_i.data_ok & s_req_o.data_ok &
                     (s_req_o.write ? s_req_o.data_last : s_resp_i.data_last);

  // grant_q is zero outside a transaction, so it doubles as the owner gate.
  always_comb begin
    m_resp_o = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      m_resp_o[i].r_data    = s_resp_i.r_data;
      m_resp_o[i].ready     = grant_q[i] & (state_q == ST_ADDR) & s_resp_i.ready;
      m_resp_o[i].data_ok   = grant_q[i] & (state_q == ST_DATA) & s_resp_i.data_ok;
      m_resp_o[i].data_last = grant_q[i] & (state_q == ST_DATA) & s_resp_i.data_last;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

  // The owner must keep its request up until the slave accepts the address.
  a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_ADDR) |-> m_req_i[owner].valid);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
module tb_cache_bus_arbiter;
  import cache_bus_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  cache_bus_req_t  [1:0] m_req;
  cache_bus_resp_t [1:0] m_resp;
  cache_bus_req_t        s_req;
  cache_bus_resp_t       s_resp;
  logic [1:0]            grant;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  cache_bus_arbiter #(.N_MASTER(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req_i  (m_req),
    .m_resp_o (m_resp),
    .s_req_o  (s_req),
    .s_resp_i (s_resp),
    .grant_o  (grant),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst_n  = 1'b0;
    m_req  = '0;
    s_resp = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    m_req  = '0;
    s_resp = '0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sreq_zero", 32'(s_req != '0), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_ctl", 32'({m_resp[0].ready, m_resp[0].data_ok, m_resp[0].data_last,
                               m_resp[1].ready, m_resp[1].data_ok, m_resp[1].data_last}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single read by master 1
    tick;
    m_req[1].valid   = 1'b1;
    m_req[1].addr    = 32'h1C00_0004;
    m_req[1].data_ok = 1'b1;
    #1;
    check("rd_req_cycle_svalid", 32'(s_req.valid), 32'd0);
    tick;
    check("rd_svalid_next", 32'(s_req.valid), 32'd1);
    check("rd_saddr", s_req.addr, 32'h1C00_0004);
    check("rd_grant", 32'(grant), 32'd2);
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_m1_ready_early", 32'(m_resp[1].ready), 32'd0);
    tick;
    s_resp.ready = 1'b1;
    #1;
    check("rd_m1_ready", 32'(m_resp[1].ready), 32'd1);
    check("rd_m0_ready", 32'(m_resp[0].ready), 32'd0);
    tick;
    m_req[1].valid   = 1'b0;
    s_resp.ready     = 1'b0;
    s_resp.data_ok   = 1'b1;
    s_resp.data_last = 1'b1;
    s_resp.r_data    = 32'hDEAD_BEEF;
    #1;
    check("rd_m1_data_ok", 32'(m_resp[1].data_ok), 32'd1);
    check("rd_m1_rdata", m_resp[1].r_data, 32'hDEAD_BEEF);
    check("rd_svalid_data", 32'(s_req.valid), 32'd0);
    tick;
    s_resp   = '0;
    m_req[1] = '0;
    #1;
    check("rd_m1_data_ok_once", 32'(m_resp[1].data_ok), 32'd0);
    check("rd_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("rd_busy_done", 32'(busy), 32'd0);

    // Contention straight after reset
    do_reset;
    m_req[0].valid   = 1'b1;
    m_req[0].addr    = 32'h1C00_00A0;
    m_req[0].data_ok = 1'b1;
    m_req[1].valid   = 1'b1;
    m_req[1].addr    = 32'h1C00_00B0;
    m_req[1].data_ok = 1'b1;
    #1;
    check("ct_idle_busy", 32'(busy), 32'd0);
    tick;
    check("ct_first_grant", 32'(grant), 32'd1);
    check("ct_first_addr", s_req.addr, 32'h1C00_00A0);
    s_resp.ready = 1'b1;
    #1;
    check("ct_m0_ready", 32'(m_resp[0].ready), 32'd1);
    check("ct_m1_ready", 32'(m_resp[1].ready), 32'd0);
    tick;
    m_req[0].valid   = 1'b0;
    s_resp.ready     = 1'b0;
    s_resp.data_ok   = 1'b1;
    s_resp.data_last = 1'b1;
    #1;
    check("ct_m0_data_ok", 32'(m_resp[0].data_ok), 32'd1);
    check("ct_m1_data_ok", 32'(m_resp[1].data_ok), 32'd0);
    tick;
    s_resp = '0;
    #1;
    check("ct_gap_grant", 32'(grant), 32'd0);
    tick;
    check("ct_second_grant", 32'(grant), 32'd2);
    check("ct_second_addr", s_req.addr, 32'h1C00_00B0);
    s_resp.ready = 1'b1;
    tick;
    m_req[1].valid   = 1'b0;
    s_resp.ready     = 1'b0;
    s_resp.data_ok   = 1'b1;
    s_resp.data_last = 1'b1;
    tick;
    s_resp         = '0;
    m_req[0].valid = 1'b1;
    m_req[1].valid = 1'b1;
    #1;
    check("ct_round2_idle", 32'(busy), 32'd0);
    tick;
    check("ct_round2_grant", 32'(grant), 32'd1);

    // Single-beat write by master 0
    do_reset;
    m_req[0].valid  = 1'b1;
    m_req[0].write  = 1'b1;
    m_req[0].addr   = 32'h1C00_0100;
    m_req[0].strobe = 4'b0001;
    m_req[0].w_data = 32'h0000_00AB;
    tick;
    check("wr_grant", 32'(grant), 32'd1);
    check("wr_swrite", 32'(s_req.write), 32'd1);
    check("wr_sstrobe", 32'(s_req.strobe), 32'd1);
    check("wr_swdata", s_req.w_data, 32'h0000_00AB);
    check("wr_sdata_ok_addr", 32'(s_req.data_ok), 32'd0);
    s_resp.ready = 1'b1;
    tick;
    m_req[0].valid     = 1'b0;
    m_req[0].data_ok   = 1'b1;
    m_req[0].data_last = 1'b1;
    s_resp.ready       = 1'b0;
    #1;
    check("wr_sdata_ok", 32'(s_req.data_ok), 32'd1);
    check("wr_sdata_last", 32'(s_req.data_last), 32'd1);
    check("wr_no_done_yet", 32'(dut.xfer_done), 32'd0);
    tick;
    s_resp.data_ok = 1'b1;
    #1;
    check("wr_busy_hold", 32'(busy), 32'd1);
    check("wr_done", 32'(dut.xfer_done), 32'd1);
    tick;
    s_resp   = '0;
    m_req[0] = '0;
    #1;
    check("wr_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // 4-beat burst by master 0, master 1 requests mid-burst
    m_req[0].valid   = 1'b1;
    m_req[0].addr    = 32'h1C00_2000;
    m_req[0].len     = 8'd3;
    m_req[0].data_ok = 1'b1;
    tick;
    check("bu_grant", 32'(grant), 32'd1);
    s_resp.ready = 1'b1;
    tick;
    m_req[0].valid   = 1'b0;
    s_resp.ready     = 1'b0;
    m_req[1].valid   = 1'b1;
    m_req[1].addr    = 32'h1C00_3000;
    m_req[1].data_ok = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_resp.data_ok   = 1'b1;
      s_resp.data_last = (b == 3);
      s_resp.r_data    = 32'h0000_1000 + 32'(b);
      #1;
      check($sformatf("bu_m0_data_ok_%0d", b), 32'(m_resp[0].data_ok), 32'd1);
      check($sformatf("bu_m0_rdata_%0d", b), m_resp[0].r_data, 32'h0000_1000 + 32'(b));
      check($sformatf("bu_m1_quiet_%0d", b), 32'({m_resp[1].ready, m_resp[1].data_ok}), 32'd0);
      check($sformatf("bu_grant_%0d", b), 32'(grant), 32'd1);
      tick;
    end
    s_resp   = '0;
    m_req[0] = '0;
    #1;
    check("bu_idle_busy", 32'(busy), 32'd0);
    check("bu_idle_m1_quiet", 32'({m_resp[1].ready, m_resp[1].data_ok}), 32'd0);
    tick;
    check("bu_m1_grant", 32'(grant), 32'd2);
    check("bu_m1_addr", s_req.addr, 32'h1C00_3000);

    // Non-owner isolation while master 1 owns the bus
    s_resp.ready = 1'b1;
    tick;
    m_req[1].valid = 1'b0;
    s_resp.ready   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_resp.data_ok   = (i % 2 == 1);
      s_resp.data_last = 1'b0;
      #1;
      check($sformatf("iso_m0_data_ok_%0d", i), 32'(m_resp[0].data_ok), 32'd0);
      check($sformatf("iso_m1_data_ok_%0d", i), 32'(m_resp[1].data_ok), 32'(i % 2));
      tick;
    end
    check("iso_still_busy", 32'(busy), 32'd1);

    // Reset in the middle of the data phase
    #2;
    rst_n            = 1'b0;
    s_resp           = '0;
    m_req[0].valid   = 1'b1;
    m_req[0].addr    = 32'h1C00_4000;
    m_req[0].data_ok = 1'b1;
    m_req[1].valid   = 1'b1;
    #1;
    check("mr_svalid", 32'(s_req.valid), 32'd0);
    check("mr_grant", 32'(grant), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("mr_idle_after", 32'(busy), 32'd0);
    tick;
    check("mr_first_grant", 32'(grant), 32'd1);
    check("mr_first_addr", s_req.addr, 32'h1C00_4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Shares one downstream `cache_bus` port between `N_MASTER` upstream requesters, such as the instruction-fetch path and the uncached LSU path. Grants are round-robin. Each grant is held from address acceptance through the final data beat, so a transaction is never interleaved with another. The block sits between the core-side masters (`lsu`, icache/dcache refill) and the AXI bridge.

## Interface
Parameters:
- `N_MASTER`, default 2: number of upstream requesters; must be 2..4.

Ports:
- `clk`  in  1: core clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `m_req_i`  in  `cache_bus_req_t [N_MASTER-1:0]`: upstream requests.
- `m_resp_o`  out  `cache_bus_resp_t [N_MASTER-1:0]`: upstream responses.
- `s_req_o`  out  `cache_bus_req_t`: downstream request.
- `s_resp_i`  in  `cache_bus_resp_t`: downstream response.
- `grant_o`  out  `N_MASTER`: one-hot current owner; 0 when idle.
- `busy_o`  out  1: high in `ST_ADDR` or `ST_DATA`.

## Operation
- The FSM is one-hot with three states.
  - `ST_IDLE`: if any `m_req_i[i].valid` is high, choose a winner by round-robin, register it in `grant_q`, and go to `ST_ADDR`.
  - `ST_ADDR`: go to `ST_DATA` when `s_resp_i.ready` is high.
  - `ST_DATA`: go to `ST_IDLE` when `xfer_done` is high.
- Round-robin rule:
  - Priority search starts at `(last_q + 1) mod N_MASTER`.
  - `last_q` updates to the winner when entering `ST_ADDR`.
  - `last_q` resets to `N_MASTER-1`, so master 0 wins first.
- Request muxing:
  - `s_req_o` carries the fields of `m_req_i[owner]`.
  - `s_req_o.valid` is forced to `(state == ST_ADDR)`.
  - `s_req_o.data_ok` is forced low outside `ST_DATA`.
  - All fields are 0 in `ST_IDLE`.
- Response routing:
  - `m_resp_o[owner]` equals `s_resp_i`, with `ready` gated to `ST_ADDR` and `data_ok`/`data_last` gated to `ST_DATA`.
  - Every non-owner sees `ready`, `data_ok` and `data_last` at 0; `r_data` passes through ungated.
- `xfer_done = s_resp_i.data_ok & s_req_o.data_ok & (s_req_o.write ? s_req_o.data_last : s_resp_i.data_last)`.
- A burst stays in `ST_DATA` over multiple beats until `xfer_done`.
- Masters must hold `valid` and all address fields stable until they see `ready`. Dropping `valid` in `ST_ADDR` is a protocol violation and is flagged by an assertion; no recovery logic is provided.
- Reset mid-transaction:
  - The FSM returns to `ST_IDLE`, `grant_q` is cleared and `last_q` is reset.
  - The downstream slave is reset by the same `rst_n`.

## Timing
- Arbitration latency is one cycle: an upstream `valid` first seen in cycle T gives `s_req_o.valid` in T+1.
- Back-to-back transactions:
  - `xfer_done` in cycle T returns the FSM to `ST_IDLE` in T+1.
  - The next grant is made in T+1, with `s_req_o.valid` in T+2.
  - Minimum gap is one idle cycle.
- Simultaneous requests in `ST_IDLE`: exactly one winner, per the round-robin rule. The losers keep `valid` high and are served in later arbitrations.
- A request that arrives while the FSM is busy waits, with no loss; it is evaluated in the next `ST_IDLE` cycle.
- Outputs during reset and after release: `s_req_o` = 0, `m_resp_o` control bits = 0, `grant_o` = 0, `busy_o` = 0.
- Registered: `state`, `grant_q`, `last_q`. All bus outputs are combinational from these registers and the inputs, with no extra pipeline stage.

## Structure
- `cache_bus_req_t` and `cache_bus_resp_t` stay in `lsu_types.svh`.
- New shared constants go into the same header: state encodings `ST_IDLE = 3'b001`, `ST_ADDR = 3'b010`, `ST_DATA = 3'b100`.
- One sub-module, `rr_picker`:
  - Inputs: request vector and `last_q`.
  - Output: one-hot winner.
  - Purely combinational; reusable for the future TLB/refill arbiter.
- FSM and muxing stay in the top module.

## Test plan
- **Single read.** Master 1 issues a read at `addr 0x1C00_0004`; slave asserts `ready` 2 cycles later and returns `r_data 0xDEAD_BEEF` with `data_last`. Required:
  - `s_req_o.valid` rises one cycle after request.
  - Master 1 sees `data_ok` exactly once with that data.
  - FSM is back in `ST_IDLE`.
- **Contention.** Both masters raise `valid` in the same cycle straight after reset. Required:
  - Master 0 is granted first and master 1 next.
  - A second simultaneous round grants master 0 again, because `last_q` = 1.
- **Write.** Master 0 writes `w_data 0x0000_00AB` with strobe `4'b0001`. Required:
  - `s_req_o` carries write=1, strobe `4'b0001`.
  - `xfer_done` occurs on the cycle where `s_req_o.data_last` and `s_resp_i.data_ok` are both high.
- **4-beat burst.** Master 0 issues a 4-beat burst read while master 1 requests mid-burst. Required:
  - Master 1 sees no `ready` or `data_ok` until master 0's 4th beat completes.
  - Master 1 is then granted one cycle after `ST_IDLE`.
- **Reset mid-transaction.** Assert `rst_n` low in `ST_DATA`. Required:
  - `s_req_o.valid`, `grant_o` and `busy_o` are 0 immediately, asynchronously.
  - After release, master 0 is granted first.
- **Non-owner isolation.** Toggle `s_resp_i.data_ok` while master 1 owns the bus. Required: `m_resp_o[0].data_ok` stays 0 throughout.
